// File: rtl/coord_link_pkg.sv
// Shared types and sizing for the cursor-coordinate link (transmitter and receiver).
// COORD_LINK_PARITY_EN appends an even-parity bit after the payload.
package coord_link_pkg;

  localparam int COORD_W      = 9;
  localparam int PAYLOAD_BITS = 2*COORD_W + 1;
`ifdef COORD_LINK_PARITY_EN
  localparam int PKT_BITS     = PAYLOAD_BITS + 1;
`else
  localparam int PKT_BITS     = PAYLOAD_BITS;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               shot;
  } coord_pkt_t;

  // Wire image of a packet, MSB transmitted first.
  function automatic logic [PKT_BITS-1:0] pkt_bits(input coord_pkt_t p);
`ifdef COORD_LINK_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/coord_link_tx_edge_sync.sv
// Two-flop synchroniser with rising-edge pulse; reusable for any VGA_VS consumer.
module edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic rise
);

  logic sync1, sync2, hist;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/coord_link_tx.sv
// Transmit end of the cursor-coordinate link: one {x, y, shot} packet per frame_clk rise.
// Build with COORD_LINK_PARITY_EN to append an even-parity bit.
module coord_link_tx
  import coord_link_pkg::*;
#(
  parameter int HALF_DIV = 25,
  parameter int GAP_BITS = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic               shot,
  output logic               tx_clk,
  output logic               tx_frame,
  output logic               tx_data,
  output logic               busy,
  output logic               overrun
);

  localparam int HW      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GAP_CYC = GAP_BITS * 2 * HALF_DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  tx_state_t           state;
  logic [HW-1:0]       half_cnt;
  logic                phase;     // 0: low half of bit-period, 1: high half
  logic [4:0]          bit_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [PKT_BITS-1:0] shreg;
  logic                req;
  coord_pkt_t          cap;

  assign cap = '{x: cursor_x, y: cursor_y, shot: shot};

  edge_sync u_vs_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .rise     (req)
  );

  // Outputs are registered one cycle behind the FSM so the link pins are glitch-free.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      tx_clk   <= 1'b0;
      tx_frame <= 1'b0;
      tx_data  <= 1'b0;
    end else begin
      tx_frame <= (state == SEND);
      tx_clk   <= (state == SEND) && phase;
      tx_data  <= (state == SEND) && shreg[PKT_BITS-1];

      // busy is a register, so a request in the cycle it falls is still dropped.
      if (req && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (req) begin
            shreg    <= pkt_bits(cap);
            busy     <= 1'b1;
            half_cnt <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (half_cnt == HW'(HALF_DIV-1)) begin
            half_cnt <= '0;
            phase    <= ~phase;
            if (phase) begin
              if (bit_cnt == 5'(PKT_BITS-1)) begin
                bit_cnt <= '0;
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                shreg   <= {shreg[PKT_BITS-2:0], 1'b0};
              end
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC-1)) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coord_link_tx.sv
// Scoreboard bench for coord_link_tx: expected packets queued at stimulus, checked at frame end.
`timescale 1ns/1ps
module tb_coord_link_tx;

  localparam int H   = 25;
  localparam int GB  = 4;
`ifdef COORD_LINK_PARITY_EN
  localparam int NB  = 20;
`else
  localparam int NB  = 19;
`endif
  localparam int FLEN = NB*2*H;
  localparam int BLEN = FLEN + GB*2*H;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [8:0] cursor_x = '0, cursor_y = '0;
  logic       shot = 1'b0;
  logic       tx_clk, tx_frame, tx_data, busy, overrun;

  int          n_checks = 0;
  int          n_errors = 0;
  int          frames_started = 0;
  logic [31:0] exp_q[$];

  always #10 Clk = ~Clk;

  coord_link_tx #(.HALF_DIV(H), .GAP_BITS(GB)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .shot(shot),
    .tx_clk(tx_clk), .tx_frame(tx_frame), .tx_data(tx_data),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [8:0] x, input logic [8:0] y, input logic s);
`ifdef COORD_LINK_PARITY_EN
    return 32'({x, y, s, ^{x, y, s}});
`else
    return 32'({x, y, s});
`endif
  endfunction

  // Monitor: receiver-style sampling on tx_clk rising edges, observed at negedge Clk.
  initial begin
    logic        pclk, pframe, pbusy;
    logic [31:0] acc, e;
    int          nbits, flen, blen;
    pclk = 0; pframe = 0; pbusy = 0; acc = 0; nbits = 0; flen = 0; blen = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        pclk = 0; pframe = 0; pbusy = 0; acc = 0; nbits = 0; flen = 0; blen = 0;
      end else begin
        if (tx_frame) flen++;
        if (busy) blen++;
        if (tx_frame && !pframe) frames_started++;
        if (tx_clk && !pclk && tx_frame) begin
          acc = {acc[30:0], tx_data};
          nbits++;
        end
        if (!tx_frame && pframe) begin
          chk("frame_len", flen, FLEN);
          chk("bit_count", nbits, NB);
          if (exp_q.size() == 0) chk("unexpected_pkt", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("pkt_data", acc, e);
          end
          acc = 0; nbits = 0; flen = 0;
        end
        if (!busy && pbusy) begin
          chk("busy_len", blen, BLEN);
          blen = 0;
        end
        pclk = tx_clk; pframe = tx_frame; pbusy = busy;
      end
    end
  end

  task automatic pulse_vs();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic s);
    @(negedge Clk);
    cursor_x = x; cursor_y = y; shot = s;
    exp_q.push_back(model(x, y, s));
    pulse_vs();
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge Clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (i == 4000) chk("timeout_done", 0, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    chk("rst_tx_clk", tx_clk, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // Latency: frame_clk rises 1 ns before edge N
    cursor_x = 9'h1A5; cursor_y = 9'h0F3; shot = 1'b1;
    exp_q.push_back(model(9'h1A5, 9'h0F3, 1'b1));
    @(posedge Clk);
    #19 frame_clk = 1'b1;
    @(posedge Clk);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1; n++;
      if (tx_frame) break;
    end
    chk("latency_frame", n, 3);
    chk("busy_at_frame", busy, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1; n++;
      if (tx_clk) break;
    end
    chk("latency_clk", n, H);
    frame_clk = 1'b0;
    wait_done();
    chk("no_overrun", overrun, 0);

    // Overrun: second request 500 cycles into SEND is dropped
    send(9'h0AA, 9'h155, 1'b0);
    for (int i = 0; i < 20 && !tx_frame; i++) @(negedge Clk);
    repeat (500) @(negedge Clk);
    pulse_vs();
    wait_done();
    chk("overrun_set", overrun, 1);
    send(9'h123, 9'h045, 1'b1);
    wait_done();
    chk("overrun_held", overrun, 1);

    // Inputs only sampled at capture
    send(9'h000, 9'h0C3, 1'b0);
    repeat (300) @(negedge Clk);
    cursor_x = 9'h1FF;
    wait_done();
    send(9'h1FF, 9'h0C3, 1'b0);
    wait_done();

    // Parity-oriented payloads
    send(9'h001, 9'h000, 1'b0);
    wait_done();
    send(9'h000, 9'h000, 1'b0);
    wait_done();

    for (int k = 0; k < 3; k++) begin
      send(9'($urandom), 9'($urandom), 1'($urandom));
      wait_done();
    end

    // Mid-packet reset during x[7]
    send(9'h1FF, 9'h1FF, 1'b1);
    for (int i = 0; i < 20 && !tx_frame; i++) @(negedge Clk);
    chk("frame_before_rst", tx_frame, 1);
    repeat (60) @(negedge Clk);
    @(posedge Clk);
    #5 Reset = 1'b1;
    #1;
    chk("arst_tx_clk", tx_clk, 0);
    chk("arst_tx_frame", tx_frame, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    n = frames_started;
    repeat (300) @(negedge Clk);
    chk("no_tx_after_rst", frames_started, n);
    chk("idle_after_rst", busy, 0);
    send(9'h05A, 9'h1A5, 1'b1);
    wait_done();
    chk("overrun_clear", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
